// File: rtl/mem_pkg.sv
// Shared types and defaults for the unified memory responder.
// The ADDR_CHECK_EN build uses addr_err() to reject misaligned or
// out-of-range byte addresses.
package mem_pkg;

  localparam int DEF_DEPTH   = 1024;
  localparam int DEF_LATENCY = 2;
  localparam int DATA_W      = 32;
  localparam int BE_W        = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // A byte address is bad when it is not word aligned or when it has
  // any bit set above the word index range.
  function automatic logic addr_err(input logic [31:0] a, input int unsigned aw);
    return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port RAM, 32-bit words, per-byte write mask.
// Read data is registered and appears the cycle after an enabled read.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [BE_W-1:0]          be_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-masked write, or registered read of the addressed word.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be_i[b]) mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/unified_mem_responder.sv
// Single-outstanding memory responder: IDLE -> WAIT -> RESP -> IDLE.
// The RESP cycle is the LATENCY-th cycle after acceptance; writes commit
// on the edge entering RESP, reads are fetched on that same edge.
// Optional macro ADDR_CHECK_EN: misaligned / out-of-range addresses answer
// with o_Err, no write and zero read data. Without it, addresses wrap.
module unified_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Req,
  input  logic        i_We,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_WData,
  input  logic [3:0]  i_ByteEn,
  output logic        o_Ready,
  output logic        o_RValid,
  output logic [31:0] o_RData,
  output logic        o_WAck,
  output logic        o_Err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, err_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic            accept, go_resp, req_err;
  logic            op_we, op_err;
  logic [AW-1:0]   op_idx;
  logic [31:0]     op_wdata, rdata;
  logic [3:0]      op_be;

  assign accept = i_Req && (state_q == IDLE);

`ifdef ADDR_CHECK_EN
  assign req_err = addr_err(i_Addr, AW);
`else
  // Low two bits and bits above the index are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_Addr[31:AW+2], i_Addr[1:0]};
  assign req_err = 1'b0;
`endif

  // Next state and counter; go_resp marks the edge that enters RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (LATENCY == 1) begin
          state_d = RESP;
          go_resp = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT: if (cnt_q == '0) begin
        state_d = RESP;
        go_resp = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY=1 the RAM acts on the accepting edge, before the latch
  // is loaded, so take operands straight from the request in IDLE.
  always_comb begin
    op_we    = we_q;
    op_err   = err_q;
    op_idx   = idx_q;
    op_wdata = wdata_q;
    op_be    = be_q;
    if (state_q == IDLE) begin
      op_we    = i_We;
      op_err   = req_err;
      op_idx   = i_Addr[AW+1:2];
      op_wdata = i_WData;
      op_be    = i_ByteEn;
    end
  end

  // State register and request latch; reset aborts any transaction.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= i_We;
        err_q   <= req_err;
        idx_q   <= i_Addr[AW+1:2];
        wdata_q <= i_WData;
        be_q    <= i_ByteEn;
      end
    end
  end

  // Reset on the RESP-entry edge must block the commit, hence the gate.
  mem_array #(.DEPTH(DEPTH)) u_mem (
    .clk_i   (i_Clk),
    .en_i    (go_resp && !i_Reset),
    .we_i    (op_we && !op_err),
    .be_i    (op_be),
    .idx_i   (op_idx),
    .wdata_i (op_wdata),
    .rdata_o (rdata)
  );

  assign o_Ready  = (state_q == IDLE);
  assign o_RValid = (state_q == RESP) && !we_q;
  assign o_WAck   = (state_q == RESP) && we_q;
`ifdef ADDR_CHECK_EN
  assign o_Err    = (state_q == RESP) && err_q;
`else
  assign o_Err    = 1'b0;
`endif
  assign o_RData  = (o_RValid && !err_q) ? rdata : 32'd0;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed bench: dut0 uses LATENCY=2, dut1 uses LATENCY=1, both DEPTH=64.
module tb_unified_mem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req [2];
  logic        we  [2];
  logic [31:0] addr[2];
  logic [31:0] wd  [2];
  logic [3:0]  be  [2];
  logic        rdy [2];
  logic        rv  [2];
  logic        wa  [2];
  logic        er  [2];
  logic [31:0] rdat[2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  unified_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut0 (
    .i_Clk(clk), .i_Reset(rst), .i_Req(req[0]), .i_We(we[0]), .i_Addr(addr[0]),
    .i_WData(wd[0]), .i_ByteEn(be[0]), .o_Ready(rdy[0]), .o_RValid(rv[0]),
    .o_RData(rdat[0]), .o_WAck(wa[0]), .o_Err(er[0])
  );

  unified_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .i_Clk(clk), .i_Reset(rst), .i_Req(req[1]), .i_We(we[1]), .i_Addr(addr[1]),
    .i_WData(wd[1]), .i_ByteEn(be[1]), .o_Ready(rdy[1]), .o_RValid(rv[1]),
    .o_RData(rdat[1]), .o_WAck(wa[1]), .o_Err(er[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on dut s; returns data/err at the pulse and cycles from
  // acceptance to the pulse. Leaves the DUT in its following IDLE cycle.
  task automatic xact(input int s, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b,
                      output logic [31:0] rd, output logic e, output int cyc);
    bit busy_ok = 1'b1;
    bit got = 1'b0;
    req[s] = 1'b1; we[s] = w; addr[s] = a; wd[s] = d; be[s] = b;
    n_cmp++;
    if (rdy[s] !== 1'b1) begin
      n_bad++; $display("FAIL xact_ready s=%0d got %b want 1", s, rdy[s]);
    end
    tick();
    req[s] = 1'b0;
    cyc = 0; rd = '0; e = 1'b0;
    while (cyc < 10 && !got) begin
      cyc++;
      if (rdy[s] !== 1'b0) busy_ok = 1'b0;
      if (rv[s] === 1'b1 || wa[s] === 1'b1) begin
        got = 1'b1; rd = rdat[s]; e = er[s];
        n_cmp++;
        if (w ? (wa[s] !== 1'b1 || rv[s] !== 1'b0) : (rv[s] !== 1'b1 || wa[s] !== 1'b0)) begin
          n_bad++; $display("FAIL pulse_kind s=%0d we=%b got rv=%b wa=%b", s, w, rv[s], wa[s]);
        end
      end
      tick();
    end
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL xact_timeout s=%0d addr=%h got no pulse want one", s, a);
    end
    n_cmp++;
    if (!busy_ok) begin
      n_bad++; $display("FAIL busy_ready s=%0d got ready high while busy want low", s);
    end
    n_cmp++;
    if (rdat[s] !== 32'd0 || rdy[s] !== 1'b1) begin
      n_bad++; $display("FAIL after_resp s=%0d got rdata=%h ready=%b want 0/1", s, rdat[s], rdy[s]);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      req[s] = 0; we[s] = 0; addr[s] = 0; wd[s] = 0; be[s] = 0;
    end
    rst = 1'b1;
    tick(); tick();
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if ({rdy[s], rv[s], wa[s], er[s], rdat[s]} !== {4'b1000, 32'd0}) begin
        n_bad++;
        $display("FAIL reset_state s=%0d got rdy=%b rv=%b wa=%b err=%b rd=%h want 1 0 0 0 0",
                 s, rdy[s], rv[s], wa[s], er[s], rdat[s]);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (rdy[0] !== 1'b1 || rv[0] !== 1'b0 || wa[0] !== 1'b0) begin
        n_bad++; $display("FAIL idle_quiet c=%0d got rdy=%b rv=%b wa=%b want 1 0 0", c, rdy[0], rv[0], wa[0]);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic e; int cyc;
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, e, cyc);
    n_cmp++;
    if (cyc !== 2) begin n_bad++; $display("FAIL wack_latency got %0d want 2", cyc); end
    xact(0, 1'b0, 32'h10, 32'h0, 4'b0000, rd, e, cyc);
    n_cmp++;
    if (cyc !== 2 || rd !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL read_full got lat=%0d data=%h want 2 deadbeef", cyc, rd);
    end
    xact(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, e, cyc);
    xact(0, 1'b0, 32'h10, 32'h0, 4'b0000, rd, e, cyc);
    n_cmp++;
    if (rd !== 32'hDEADBEAA) begin n_bad++; $display("FAIL byte_lane0 got %h want deadbeaa", rd); end
    xact(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, e, cyc);
    n_cmp++;
    if (cyc !== 2) begin n_bad++; $display("FAIL be0_ack got lat=%0d want 2", cyc); end
    xact(0, 1'b1, 32'h10, 32'h5500CC00, 4'b1010, rd, e, cyc);
    xact(0, 1'b0, 32'h10, 32'h0, 4'b0000, rd, e, cyc);
    n_cmp++;
    if (rd !== 32'h55ADCCAA) begin n_bad++; $display("FAIL byte_lanes13 got %h want 55adccaa", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic e; int cyc;
    int pulses = 0; int p1 = -1; int p2 = -1;
    logic [31:0] d1 = '0; logic [31:0] d2 = '0;
    xact(0, 1'b1, 32'h0, 32'h11111111, 4'b1111, rd, e, cyc);
    xact(0, 1'b1, 32'h4, 32'h22222222, 4'b1111, rd, e, cyc);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0;
    tick();
    for (int c = 1; c <= 8; c++) begin
      if (rv[0] === 1'b1 || wa[0] === 1'b1) begin
        pulses++;
        if (pulses == 1) begin p1 = c; d1 = rdat[0]; addr[0] = 32'h4; end
        else if (pulses == 2) begin p2 = c; d2 = rdat[0]; req[0] = 1'b0; end
      end
      tick();
    end
    req[0] = 1'b0;
    n_cmp++;
    if (pulses !== 2) begin n_bad++; $display("FAIL b2b_count got %0d want 2", pulses); end
    n_cmp++;
    if (p1 !== 2 || p2 !== 5) begin n_bad++; $display("FAIL b2b_timing got %0d,%0d want 2,5", p1, p2); end
    n_cmp++;
    if (d1 !== 32'h11111111 || d2 !== 32'h22222222) begin
      n_bad++; $display("FAIL b2b_data got %h,%h want 11111111,22222222", d1, d2);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic e; int cyc;
    bit saw = 1'b0;
    xact(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, rd, e, cyc);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wd[0] = 32'h12345678; be[0] = 4'b1111;
    tick();
    req[0] = 1'b0;
    n_cmp++;
    if (rdy[0] !== 1'b0) begin n_bad++; $display("FAIL abort_wait got ready=%b want 0", rdy[0]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (rdy[0] !== 1'b1 || wa[0] !== 1'b0) begin
      n_bad++; $display("FAIL abort_reset got rdy=%b wa=%b want 1 0", rdy[0], wa[0]);
    end
    for (int c = 0; c < 4; c++) begin
      if (wa[0] === 1'b1 || rv[0] === 1'b1) saw = 1'b1;
      tick();
    end
    n_cmp++;
    if (saw) begin n_bad++; $display("FAIL abort_pulse got a pulse want none"); end
    xact(0, 1'b0, 32'h20, 32'h0, 4'b0000, rd, e, cyc);
    n_cmp++;
    if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL abort_mem got %h want cafef00d", rd); end
  endtask

  task automatic test_addr();
    logic [31:0] rd; logic e; int cyc;
`ifdef ADDR_CHECK_EN
    xact(0, 1'b0, 32'h13, 32'h0, 4'b0000, rd, e, cyc);
    n_cmp++;
    if (e !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL err_read got err=%b data=%h want 1 0", e, rd); end
    xact(0, 1'b1, DEPTH * 4, 32'h5A5A5A5A, 4'b1111, rd, e, cyc);
    n_cmp++;
    if (e !== 1'b1) begin n_bad++; $display("FAIL err_write got err=%b want 1", e); end
    xact(0, 1'b0, 32'h0, 32'h0, 4'b0000, rd, e, cyc);
    n_cmp++;
    if (e !== 1'b0 || rd !== 32'h11111111) begin
      n_bad++; $display("FAIL err_nowrite got err=%b data=%h want 0 11111111", e, rd);
    end
`else
    xact(0, 1'b1, DEPTH * 4, 32'h5A5A5A5A, 4'b1111, rd, e, cyc);
    n_cmp++;
    if (e !== 1'b0) begin n_bad++; $display("FAIL alias_err got %b want 0", e); end
    xact(0, 1'b0, 32'h0, 32'h0, 4'b0000, rd, e, cyc);
    n_cmp++;
    if (rd !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL alias_word0 got %h want 5a5a5a5a", rd); end
    xact(0, 1'b0, 32'h13, 32'h0, 4'b0000, rd, e, cyc);
    n_cmp++;
    if (e !== 1'b0 || rd !== 32'h55ADCCAA) begin
      n_bad++; $display("FAIL lowbits_ignored got err=%b data=%h want 0 55adccaa", e, rd);
    end
`endif
  endtask

  task automatic test_latency1();
    logic [31:0] rd; logic e; int cyc;
    int pulses = 0; int p1 = -1; int p2 = -1;
    xact(1, 1'b1, 32'h10, 32'h0BADF00D, 4'b1111, rd, e, cyc);
    n_cmp++;
    if (cyc !== 1) begin n_bad++; $display("FAIL l1_wack_latency got %0d want 1", cyc); end
    xact(1, 1'b0, 32'h10, 32'h0, 4'b0000, rd, e, cyc);
    n_cmp++;
    if (cyc !== 1 || rd !== 32'h0BADF00D) begin
      n_bad++; $display("FAIL l1_read got lat=%0d data=%h want 1 0badf00d", cyc, rd);
    end
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10;
    tick();
    for (int c = 1; c <= 6; c++) begin
      if (rv[1] === 1'b1) begin
        pulses++;
        if (pulses == 1) p1 = c;
        else if (pulses == 2) begin p2 = c; req[1] = 1'b0; end
      end
      tick();
    end
    req[1] = 1'b0;
    n_cmp++;
    if (pulses !== 2 || p1 !== 1 || p2 !== 3) begin
      n_bad++; $display("FAIL l1_period got n=%0d at %0d,%0d want 2 at 1,3", pulses, p1, p2);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_abort();
    test_addr();
    test_latency1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/unified_mem_responder.md
UNIFIED_MEM_RESPONDER -- requirements
Module: unified_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, memory size in 32-bit words (power of two, >=4).
REQ-002 SHALL have parameter LATENCY, default 2, acceptance-to-response delay in cycles (>=1).
REQ-003 SHALL have port i_Clk, input, 1, single clock, all state updates on its rising edge.
REQ-004 SHALL have port i_Reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port i_Req, input, 1, request valid from the processor.
REQ-006 SHALL have port i_We, input, 1, 1=write, 0=read.
REQ-007 SHALL have port i_Addr, input, 32, byte address.
REQ-008 SHALL have port i_WData, input, 32, write data.
REQ-009 SHALL have port i_ByteEn, input, 4, write byte enables, bit n enables byte lane n.
REQ-010 SHALL have port o_Ready, output, 1, responder can accept a request this cycle.
REQ-011 SHALL have port o_RValid, output, 1, one-cycle read-data-valid pulse.
REQ-012 SHALL have port o_RData, output, 32, read data, valid only with o_RValid.
REQ-013 SHALL have port o_WAck, output, 1, one-cycle write-completion pulse.
REQ-014 SHALL have port o_Err, output, 1, error flag, valid only with o_RValid or o_WAck.

Function
REQ-015 SHALL implement the FSM IDLE -> WAIT -> RESP -> IDLE; o_Ready is high only in IDLE.
REQ-016 SHALL accept a request on an edge where i_Req=1 and o_Ready=1, latching i_We, i_Addr, i_WData and i_ByteEn.
REQ-017 SHALL go from IDLE to WAIT on acceptance when LATENCY>1, and directly to RESP when LATENCY=1.
REQ-018 SHALL hold WAIT for LATENCY-1 cycles using a down-counter, then enter RESP, so RESP occupies exactly the LATENCY-th cycle after acceptance.
REQ-019 SHALL, in RESP, assert o_RValid (read) or o_WAck (write) for exactly one cycle, then return to IDLE; sustained throughput is one request per LATENCY+1 cycles.
REQ-020 SHALL commit a write on the edge entering RESP, updating only the lanes enabled by i_ByteEn; a write with ByteEn=0000 still acks and changes nothing.
REQ-021 SHALL return the full word on a read, reflecting all writes whose WAck preceded the read's acceptance.
REQ-022 SHALL ignore i_Req while o_Ready=0 without queuing it; the requester holds the request until accepted.
REQ-023 SHALL drive o_RData=0 outside o_RValid cycles.
REQ-024 SHALL use word index i_Addr[log2(DEPTH)+1:2].

Reset
REQ-025 SHALL, on i_Reset, set the state to IDLE, the counter to 0, o_Ready=1 and o_RValid, o_WAck, o_Err and o_RData to 0.
REQ-026 SHALL, if reset arrives mid-transaction, abort the transaction with no response, and SHALL not commit a pending write unless its commit edge has already passed.
REQ-027 SHALL NOT clear memory contents on reset.

Configuration
REQ-028 SHALL, with ADDR_CHECK_EN defined, flag a transaction as an error if i_Addr[1:0]!=0 or any i_Addr bit above log2(DEPTH)+1 is set.
REQ-029 SHALL, for such an error, raise o_Err with the response pulse, suppress the write and return o_RData=0.
REQ-030 SHALL, without ADDR_CHECK_EN, tie o_Err to 0, ignore the low two address bits and discard the upper address bits, so addresses wrap modulo DEPTH*4.

Structure
REQ-031 SHALL place the state enum (IDLE, WAIT, RESP) and the default widths in the shared package mem_pkg.
REQ-032 SHALL instantiate one sub-module, mem_array: a synchronous single-port RAM with a 4-bit byte-write mask.

Verification
REQ-033 Reset, then idle -> o_Ready=1, no pulses; write 0xDEADBEEF to 0x10 with ByteEn=1111, LATENCY=2 -> o_WAck exactly 2 cycles after acceptance, o_Ready low for 2 cycles.
REQ-034 Read 0x10 -> o_RValid 2 cycles after acceptance with o_RData=0xDEADBEEF; write 0x000000AA to 0x10 with ByteEn=0001, then read -> 0xDEADBEAA.
REQ-035 Hold i_Req high for back-to-back reads of 0x0 and 0x4 -> second accepted in the cycle after the first o_RValid; requests while busy produce no extra responses.
REQ-036 Assert reset during WAIT of a write of 0x12345678 to 0x20 -> no o_WAck; a read of 0x20 returns the prior value.
REQ-037 With ADDR_CHECK_EN, read 0x13 and write DEPTH*4 -> o_Err=1 with the pulse, data 0, memory unchanged; without ADDR_CHECK_EN, a write to DEPTH*4 aliases to word 0.
REQ-038 With LATENCY=1, a read of 0x10 -> o_RValid in the cycle after acceptance, with a 2-cycle request period.
